// File: rtl/spi_host_pkg.sv
// Shared types and frame layout helpers for the SPI host adapter.
// Frame out: {val_wrt, val_rd, payload}; frame in: {val, spc, data}.
package spi_host_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  function automatic int wrt_bit(input int n);
    return n - 1;
  endfunction

  function automatic int rd_bit(input int n);
    return n - 2;
  endfunction

  function automatic int val_bit(input int n);
    return n - 1;
  endfunction

  function automatic int spc_bit(input int n);
    return n - 2;
  endfunction

endpackage

// File: rtl/spi_host_adapter_ctrl.sv
// Frame sequencer: FSM, minion space flag, protocol error, poll timer.
// Build option: SPI_HOST_ADAPTER_POLL_EN rate-limits read-only polls.
module spi_host_adapter_ctrl
  import spi_host_pkg::*;
#(
`ifdef SPI_HOST_ADAPTER_POLL_EN
  parameter int POLL_CYCLES = 16
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic recv_val,
  input  logic rd_ok,
  input  logic spi_send_rdy,
  input  logic spi_recv_val,
  input  logic resp_val,
  input  logic resp_spc,
  output logic spi_send_val,
  output logic spi_recv_rdy,
  output logic do_wr,
  output logic do_rd,
  output logic spc_flag,
  output logic proto_err
);

  state_t state;
  logic   wr_go;
  logic   rd_go;
  logic   start;

  assign wr_go = recv_val & spc_flag;
  assign start = (state == IDLE) & (wr_go | rd_go);

`ifdef SPI_HOST_ADAPTER_POLL_EN
  localparam int CW =
    (POLL_CYCLES > 0) ? $clog2(POLL_CYCLES + 1) : 1;

  logic [CW-1:0] cnt;
  logic          poll_ok;

  assign poll_ok = (cnt == CW'(POLL_CYCLES));
  assign rd_go   = rd_ok & (wr_go | poll_ok);

  // Cycles since the last issued frame, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (!poll_ok) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign rd_go = rd_ok;
`endif

  // One frame in flight: latch intent, hand off, await reply.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      spi_send_val <= 1'b0;
      spi_recv_rdy <= 1'b0;
      do_wr        <= 1'b0;
      do_rd        <= 1'b0;
      spc_flag     <= 1'b1;
      proto_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            do_wr        <= wr_go;
            do_rd        <= rd_go;
            spi_send_val <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (spi_send_rdy) begin
            spi_send_val <= 1'b0;
            spi_recv_rdy <= 1'b1;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (spi_recv_val) begin
            spi_recv_rdy <= 1'b0;
            spc_flag     <= resp_spc;
            if (resp_val && !do_rd) begin
              proto_err <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/spi_host_adapter.sv
// Host side of the SPI val/rdy tunnel: frame packing and read buffer.
// Build option: SPI_HOST_ADAPTER_POLL_EN enables rate-limited polling.
module spi_host_adapter
  import spi_host_pkg::*;
#(
  parameter int nbits       = 8,
  parameter int num_entries = 2
`ifdef SPI_HOST_ADAPTER_POLL_EN
  , parameter int POLL_CYCLES = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             recv_val,
  output logic             recv_rdy,
  input  logic [nbits-3:0] recv_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic [nbits-3:0] send_msg,
  output logic             spi_send_val,
  input  logic             spi_send_rdy,
  output logic [nbits-1:0] spi_send_msg,
  input  logic             spi_recv_val,
  output logic             spi_recv_rdy,
  input  logic [nbits-1:0] spi_recv_msg,
  output logic             proto_err
);

  localparam int WRT_BIT = wrt_bit(nbits);
  localparam int RD_BIT  = rd_bit(nbits);
  localparam int VAL_BIT = val_bit(nbits);
  localparam int SPC_BIT = spc_bit(nbits);
  localparam int PW =
    (num_entries > 1) ? $clog2(num_entries) : 1;
  localparam int CW = $clog2(num_entries + 1);

  logic             do_wr;
  logic             do_rd;
  logic             spc_flag;
  logic             rd_ok;
  logic             push;
  logic             pop;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [nbits-3:0] mem [num_entries];

  spi_host_adapter_ctrl
`ifdef SPI_HOST_ADAPTER_POLL_EN
    #(.POLL_CYCLES(POLL_CYCLES))
`endif
  u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .recv_val     (recv_val),
    .rd_ok        (rd_ok),
    .spi_send_rdy (spi_send_rdy),
    .spi_recv_val (spi_recv_val),
    .resp_val     (spi_recv_msg[VAL_BIT]),
    .resp_spc     (spi_recv_msg[SPC_BIT]),
    .spi_send_val (spi_send_val),
    .spi_recv_rdy (spi_recv_rdy),
    .do_wr        (do_wr),
    .do_rd        (do_rd),
    .spc_flag     (spc_flag),
    .proto_err    (proto_err)
  );

  // A read is only requested while a slot is free; with a
  // single frame in flight that slot cannot be taken away.
  assign rd_ok    = (count != CW'(num_entries));
  assign push     = spi_recv_val & spi_recv_rdy
                  & spi_recv_msg[VAL_BIT] & do_rd;
  assign pop      = send_val & send_rdy;
  assign send_val = (count != '0);
  assign send_msg = mem[rd_ptr];
  assign recv_rdy = spi_send_val & do_wr & spi_send_rdy;

  // Outgoing frame built from the latched request bits.
  always_comb begin
    spi_send_msg          = '0;
    spi_send_msg[WRT_BIT] = do_wr;
    spi_send_msg[RD_BIT]  = do_rd;
    if (do_wr) begin
      spi_send_msg[nbits-3:0] = recv_msg;
    end
  end

  // Read-data storage.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= spi_recv_msg[nbits-3:0];
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(num_entries - 1))
                ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(num_entries - 1))
                ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule
